pipeline_sequencer: RTL and testbench

Central control block for the five-stage pipeline (IF, ID, EX, MEM, WB). It owns run/halt/single-step sequencing, detects load-use hazards, and raises the stall and bubble controls. It also generates taken-branch flushes, freezes the whole pipe while data memory is busy, and drains in-flight instructions on halt. It sits beside the stage blocks and drives their write enables; it holds no datapath state.

---
 rtl/pipeline_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/halt/single-step control for the five-stage pipe.
// Detects load-use hazards, generates stall/bubble/flush controls, freezes
// the pipe while data memory is busy and drains in-flight work on halt.
//
// Ports:
//   Clk, Rst_n                 clock, async active-low reset
//   Start, HaltReq, StepReq    run control requests (levels)
//   IDHalt, Branch, Jump       decode-stage events
//   EXMemRead, EXRd            load in EX and its destination
//   IDRs, IDRt, IDUsesRt       ID source operands
//   MemReq, MemAck             data-memory handshake
//   StageEn[4:0]               per-stage advance enable (bit0 = IF .. bit4 = WB)
//   PCWrite, IFIDFlush,
//   IDEXBubble                 pipeline register controls (combinational)
//   Running, Halted            status
//   CycleCount, StallCount     performance counters
//
// Build option: define PIPE_PERF_CNT_EN to implement the performance
// counters; otherwise both counter outputs are tied to zero.
module pipeline_sequencer #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             HaltReq,
    input  logic             StepReq,
    input  logic             IDHalt,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             EXMemRead,
    input  logic [4:0]       EXRd,
    input  logic [4:0]       IDRs,
    input  logic [4:0]       IDRt,
    input  logic             IDUsesRt,
    input  logic             MemReq,
    input  logic             MemAck,
    output logic [4:0]       StageEn,
    output logic             PCWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             Running,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] StallCount
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_HALTED = 3'd3,
        S_STEP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 freeze;
    logic                 load_use;

    // Memory busy freezes everything; load-use hazard on a load in EX.
    assign freeze   = MemReq & ~MemAck;
    assign load_use = EXMemRead & (EXRd != 5'd0) &
                      ((EXRd == IDRs) | (IDUsesRt & (EXRd == IDRt)));

    // State and drain counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state and combinational pipe controls.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        StageEn     = 5'b00000;
        PCWrite     = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        Running     = 1'b0;
        Halted      = 1'b0;

        // RUN and STEP share the same pipe-control priority:
        // freeze, then load-use stall, then branch/jump flush.
        if ((state_q == S_RUN) || (state_q == S_STEP)) begin
            if (freeze) begin
                StageEn = 5'b00000;
            end else if (load_use) begin
                StageEn    = 5'b11100;
                IDEXBubble = 1'b1;
            end else begin
                StageEn   = 5'b11111;
                PCWrite   = 1'b1;
                IFIDFlush = Branch | Jump;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_RUN;
            end
            S_RUN: begin
                Running = 1'b1;
                if (!freeze && (IDHalt || HaltReq)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
                end
            end
            S_DRAIN: begin
                Running = 1'b1;
                if (!freeze) begin
                    StageEn     = 5'b11110;
                    IFIDFlush   = 1'b1;
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    // <= also covers a zero count so the drain can never stick.
                    if (drain_cnt_q <= DRAIN_W'(1)) state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                Halted = 1'b1;
                if (Start)        state_d = S_RUN;
                else if (StepReq) state_d = S_STEP;
            end
            S_STEP: begin
                Running = 1'b1;
                // IDHalt is deliberately ignored while stepping.
                if (!freeze) state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters; cleared only on a fresh start from IDLE.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && Start) begin
            cycle_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (Running && (cycle_cnt_q != {CNT_W{1'b1}}))
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if ((state_q == S_RUN) && !PCWrite && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign CycleCount = cycle_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    assign CycleCount = '0;
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer.
// Control outputs are compared as one vector:
//   {StageEn[4:0], PCWrite, IFIDFlush, IDEXBubble, Running, Halted}
module tb_pipeline_sequencer;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [9:0] IDLE_O   = 10'b00000_0_0_0_0_0;
    localparam logic [9:0] RUN_O    = 10'b11111_1_0_0_1_0;
    localparam logic [9:0] STALL_O  = 10'b11100_0_0_1_1_0;
    localparam logic [9:0] FLUSH_O  = 10'b11111_1_1_0_1_0;
    localparam logic [9:0] FREEZE_O = 10'b00000_0_0_0_1_0;
    localparam logic [9:0] DRAIN_O  = 10'b11110_0_1_0_1_0;
    localparam logic [9:0] HALT_O   = 10'b00000_0_0_0_0_1;

    logic        Clk, Rst_n;
    logic        Start, HaltReq, StepReq, IDHalt, Branch, Jump;
    logic        EXMemRead, IDUsesRt, MemReq, MemAck;
    logic [4:0]  EXRd, IDRs, IDRt;
    logic [4:0]  StageEn, StageEn4;
    logic        PCWrite, IFIDFlush, IDEXBubble, Running, Halted;
    logic        PCWrite4, IFIDFlush4, IDEXBubble4, Running4, Halted4;
    logic [15:0] CycleCount, StallCount;
    logic [3:0]  CycleCount4, StallCount4;
    logic [9:0]  ctl;

    int compared   = 0;
    int mismatched = 0;

    assign ctl = {StageEn, PCWrite, IFIDFlush, IDEXBubble, Running, Halted};

    pipeline_sequencer #(.CNT_W(16), .DRAIN_CYCLES(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .HaltReq(HaltReq), .StepReq(StepReq),
        .IDHalt(IDHalt), .Branch(Branch), .Jump(Jump), .EXMemRead(EXMemRead),
        .EXRd(EXRd), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .MemReq(MemReq), .MemAck(MemAck), .StageEn(StageEn), .PCWrite(PCWrite),
        .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble), .Running(Running),
        .Halted(Halted), .CycleCount(CycleCount), .StallCount(StallCount)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pipeline_sequencer #(.CNT_W(4), .DRAIN_CYCLES(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .HaltReq(HaltReq), .StepReq(StepReq),
        .IDHalt(IDHalt), .Branch(Branch), .Jump(Jump), .EXMemRead(EXMemRead),
        .EXRd(EXRd), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .MemReq(MemReq), .MemAck(MemAck), .StageEn(StageEn4), .PCWrite(PCWrite4),
        .IFIDFlush(IFIDFlush4), .IDEXBubble(IDEXBubble4), .Running(Running4),
        .Halted(Halted4), .CycleCount(CycleCount4), .StallCount(StallCount4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected counter value: counters read zero when not built in.
    function automatic int pexp(input int v);
        pexp = PERF ? v : 0;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Start = 0; HaltReq = 0; StepReq = 0; IDHalt = 0; Branch = 0; Jump = 0;
        EXMemRead = 0; IDUsesRt = 0; MemReq = 0; MemAck = 0;
        EXRd = 5'd0; IDRs = 5'd0; IDRt = 5'd0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        clear_inputs();
        #2;
        if (ctl !== IDLE_O) begin $display("FAIL reset_ctl: got %b want %b", ctl, IDLE_O); mismatched++; end
        compared++;
        if (CycleCount !== 16'd0) begin $display("FAIL reset_cycle: got %0d want 0", CycleCount); mismatched++; end
        compared++;
        tick(); tick();
        Rst_n = 1'b1;
        tick();
        if (ctl !== IDLE_O) begin $display("FAIL idle_ctl: got %b want %b", ctl, IDLE_O); mismatched++; end
        compared++;
        Start = 1; #1;
        if (ctl !== IDLE_O) begin $display("FAIL idle_start_ctl: got %b want %b", ctl, IDLE_O); mismatched++; end
        compared++;
        tick();
        Start = 0; #1;
        if (ctl !== RUN_O) begin $display("FAIL start_run_ctl: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        if (CycleCount !== 16'd0) begin $display("FAIL start_cycle: got %0d want 0", CycleCount); mismatched++; end
        compared++;
    endtask

    task automatic test_load_use();
        EXMemRead = 1; EXRd = 5'd5; IDRs = 5'd5; #1;
        if (ctl !== STALL_O) begin $display("FAIL lu_rs_stall: got %b want %b", ctl, STALL_O); mismatched++; end
        compared++;
        tick();
        EXMemRead = 0; #1;   // load has moved to MEM
        if (ctl !== RUN_O) begin $display("FAIL lu_one_cycle: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick();
        EXMemRead = 1; EXRd = 5'd0; IDRs = 5'd0; #1;
        if (ctl !== RUN_O) begin $display("FAIL lu_r0_nostall: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick();
        EXRd = 5'd7; IDRs = 5'd3; IDRt = 5'd7; IDUsesRt = 1; #1;
        if (ctl !== STALL_O) begin $display("FAIL lu_rt_stall: got %b want %b", ctl, STALL_O); mismatched++; end
        compared++;
        tick();
        IDUsesRt = 0; #1;
        if (ctl !== RUN_O) begin $display("FAIL lu_rt_unused: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick();
        clear_inputs(); #1;
        if (CycleCount !== 16'(pexp(5))) begin $display("FAIL lu_cycle: got %0d want %0d", CycleCount, pexp(5)); mismatched++; end
        compared++;
        if (StallCount !== 16'(pexp(2))) begin $display("FAIL lu_stallcnt: got %0d want %0d", StallCount, pexp(2)); mismatched++; end
        compared++;
    endtask

    task automatic test_branch();
        Branch = 1; #1;
        if (ctl !== FLUSH_O) begin $display("FAIL br_flush: got %b want %b", ctl, FLUSH_O); mismatched++; end
        compared++;
        tick();
        Branch = 0; Jump = 1; #1;
        if (ctl !== FLUSH_O) begin $display("FAIL jmp_flush: got %b want %b", ctl, FLUSH_O); mismatched++; end
        compared++;
        tick();
        Jump = 0; Branch = 1; EXMemRead = 1; EXRd = 5'd9; IDRs = 5'd9; #1;
        if (ctl !== STALL_O) begin $display("FAIL br_vs_stall: got %b want %b", ctl, STALL_O); mismatched++; end
        compared++;
        tick();
        EXMemRead = 0; #1;   // branch re-resolves after the stall
        if (ctl !== FLUSH_O) begin $display("FAIL br_reresolve: got %b want %b", ctl, FLUSH_O); mismatched++; end
        compared++;
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        MemReq = 1; MemAck = 0; Branch = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ctl !== FREEZE_O) begin $display("FAIL mem_freeze%0d: got %b want %b", i, ctl, FREEZE_O); mismatched++; end
            compared++;
            tick();
        end
        MemAck = 1; Branch = 0; #1;
        if (ctl !== RUN_O) begin $display("FAIL mem_ack_adv: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick();
        clear_inputs(); #1;
        if (StallCount !== 16'(pexp(6))) begin $display("FAIL mem_stallcnt: got %0d want %0d", StallCount, pexp(6)); mismatched++; end
        compared++;
        if (CycleCount !== 16'(pexp(13))) begin $display("FAIL mem_cycle: got %0d want %0d", CycleCount, pexp(13)); mismatched++; end
        compared++;
    endtask

    task automatic test_halt_step();
        IDHalt = 1; #1;
        if (ctl !== RUN_O) begin $display("FAIL halt_accept: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick();
        IDHalt = 0;
        for (int i = 0; i < 5; i++) begin
            // a frozen cycle in the middle must not consume a drain slot
            if (i == 2) begin MemReq = 1; MemAck = 0; end
            else begin MemReq = 0; end
            #1;
            if (i == 2) begin
                if (ctl !== FREEZE_O) begin $display("FAIL drain_freeze: got %b want %b", ctl, FREEZE_O); mismatched++; end
            end else begin
                if (ctl !== DRAIN_O) begin $display("FAIL drain%0d: got %b want %b", i, ctl, DRAIN_O); mismatched++; end
            end
            compared++;
            tick();
        end
        MemReq = 0; #1;
        if (ctl !== HALT_O) begin $display("FAIL halted: got %b want %b", ctl, HALT_O); mismatched++; end
        compared++;
        tick(); #1;
        if (CycleCount !== 16'(pexp(19))) begin $display("FAIL halt_cycle: got %0d want %0d", CycleCount, pexp(19)); mismatched++; end
        compared++;
        StepReq = 1; IDHalt = 1; #1;
        if (ctl !== HALT_O) begin $display("FAIL step_req: got %b want %b", ctl, HALT_O); mismatched++; end
        compared++;
        tick();
        StepReq = 0; #1;
        if (ctl !== RUN_O) begin $display("FAIL step_run: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick(); #1;
        if (ctl !== HALT_O) begin $display("FAIL step_back: got %b want %b", ctl, HALT_O); mismatched++; end
        compared++;
        IDHalt = 0; StepReq = 1;
        tick();
        StepReq = 0; MemReq = 1; MemAck = 0; #1;
        if (ctl !== FREEZE_O) begin $display("FAIL step_freeze: got %b want %b", ctl, FREEZE_O); mismatched++; end
        compared++;
        tick();
        MemAck = 1; #1;
        if (ctl !== RUN_O) begin $display("FAIL step_ack: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        tick();
        clear_inputs(); #1;
        if (ctl !== HALT_O) begin $display("FAIL step_ack_back: got %b want %b", ctl, HALT_O); mismatched++; end
        compared++;
        Start = 1; StepReq = 1;
        tick();
        clear_inputs(); #1;
        if (ctl !== RUN_O) begin $display("FAIL resume_run: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
        if (CycleCount !== 16'(pexp(22))) begin $display("FAIL resume_cycle: got %0d want %0d", CycleCount, pexp(22)); mismatched++; end
        compared++;
        if (StallCount !== 16'(pexp(6))) begin $display("FAIL resume_stallcnt: got %0d want %0d", StallCount, pexp(6)); mismatched++; end
        compared++;
    endtask

    task automatic test_async_reset();
        HaltReq = 1; Start = 1;
        tick();
        clear_inputs(); #1;
        if (ctl !== DRAIN_O) begin $display("FAIL haltreq_drain: got %b want %b", ctl, DRAIN_O); mismatched++; end
        compared++;
        tick();
        Rst_n = 1'b0; #1;
        if (ctl !== IDLE_O) begin $display("FAIL async_rst_ctl: got %b want %b", ctl, IDLE_O); mismatched++; end
        compared++;
        if (CycleCount !== 16'd0 || StallCount !== 16'd0) begin
            $display("FAIL async_rst_cnt: got %0d/%0d want 0/0", CycleCount, StallCount); mismatched++;
        end
        compared++;
        tick(); tick();
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        Start = 1;
        tick();
        Start = 0;
        repeat (20) tick();
        if (CycleCount4 !== 4'(pexp(15))) begin $display("FAIL sat_cycle4: got %0d want %0d", CycleCount4, pexp(15)); mismatched++; end
        compared++;
        if (CycleCount !== 16'(pexp(20))) begin $display("FAIL sat_cycle16: got %0d want %0d", CycleCount, pexp(20)); mismatched++; end
        compared++;
        if (ctl !== RUN_O) begin $display("FAIL sat_ctl: got %b want %b", ctl, RUN_O); mismatched++; end
        compared++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_halt_step();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
